// File: rtl/lopd_norm_pkg.sv
// lopd_norm_pkg: shared definitions for the leading-one normalizer.
//   state_t          - controller FSM encoding
//   DEF_SIZE_*       - default widths used by lopd_norm_ctrl and lopd_core
//   DEF_SHIFT_STEP   - default per-cycle shift limit
package lopd_norm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DETECT = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int DEF_SIZE_DATA  = 24;
   localparam int DEF_SIZE_LOPD  = 5;
   localparam int DEF_SIZE_EXP   = 8;
   localparam int DEF_SHIFT_STEP = 8;

endpackage

// File: rtl/lopd_core.sv
// lopd_core: combinational leading-one position detector.
//   i_data         - word to scan
//   o_one_position - bit index of the most significant 1 (0 when i_data is 0)
//   o_zero_flag    - i_data is all zeros
module lopd_core
   import lopd_norm_pkg::*;
#(
   parameter int SIZE_DATA = DEF_SIZE_DATA,
   parameter int SIZE_LOPD = DEF_SIZE_LOPD
) (
   input  logic [SIZE_DATA-1:0] i_data,
   output logic [SIZE_LOPD-1:0] o_one_position,
   output logic                 o_zero_flag
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      o_one_position = '0;
      for (int i = 0; i < SIZE_DATA; i++) begin
         if (i_data[i]) o_one_position = SIZE_LOPD'(i);
      end
   end

   assign o_zero_flag = ~|i_data;

endmodule

// File: rtl/lopd_norm_ctrl.sv
// lopd_norm_ctrl: sequences normalization of a mantissa/exponent pair.
// Handshake in (i_valid/o_ready), leading-one detect, left shift (iterative
// or single-cycle), then holds the result until i_ready (o_valid).
//   i_clk, i_rst_n           - clock, async active-low reset
//   i_valid, o_ready         - operand handshake
//   i_mant, i_exp            - unnormalized mantissa, biased exponent
//   o_valid, i_ready         - result handshake
//   o_mant, o_exp, o_shamt   - normalized mantissa, adjusted exponent, shift
//   o_zero_flag              - mantissa was zero
//   o_denorm_flag            - exponent ran out, result is denormal
// Build option: LOPD_NORM_FAST_SHIFT_EN makes SHIFT a single cycle applying
// the full shift; otherwise SHIFT moves at most SHIFT_STEP bits per cycle.
//
// state  | meaning
// IDLE   | o_ready high, waiting for an operand
// DETECT | find leading one, decide shift, exponent and flags
// SHIFT  | shift mantissa left until the remaining count is zero
// DONE   | o_valid high, result held until i_ready
module lopd_norm_ctrl
   import lopd_norm_pkg::*;
#(
   parameter int SIZE_DATA  = DEF_SIZE_DATA,
   parameter int SIZE_LOPD  = DEF_SIZE_LOPD,
   parameter int SIZE_EXP   = DEF_SIZE_EXP,
   parameter int SHIFT_STEP = DEF_SHIFT_STEP
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_mant,
   input  logic [SIZE_EXP-1:0]  i_exp,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_mant,
   output logic [SIZE_EXP-1:0]  o_exp,
   output logic [SIZE_LOPD-1:0] o_shamt,
   output logic                 o_zero_flag,
   output logic                 o_denorm_flag
);

   // Common width so shift counts and exponents compare without truncation.
   localparam int CW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP : SIZE_LOPD;
   localparam logic [SIZE_LOPD-1:0] MSB_POS = SIZE_LOPD'(SIZE_DATA - 1);

   state_t               state_q, state_d;
   logic [SIZE_DATA-1:0] mant_q, mant_d;
   logic [SIZE_EXP-1:0]  exp_q, exp_d;
   logic [SIZE_LOPD-1:0] shamt_q, shamt_d;
   logic [SIZE_LOPD-1:0] rem_q, rem_d;
   logic                 zero_q, zero_d;
   logic                 denorm_q, denorm_d;

   logic [SIZE_LOPD-1:0] lop_pos;
   logic                 lop_zero;
   logic [CW-1:0]        raw_w, exp_w, eff_w;
   logic                 go_denorm;

   lopd_core #(
      .SIZE_DATA (SIZE_DATA),
      .SIZE_LOPD (SIZE_LOPD)
   ) u_lopd_core (
      .i_data         (mant_q),
      .o_one_position (lop_pos),
      .o_zero_flag    (lop_zero)
   );

   // When the exponent cannot absorb the full shift, stop one short of zero
   // so the biased exponent field lands on the denormal encoding.
   always_comb begin
      raw_w     = CW'(MSB_POS - lop_pos);
      exp_w     = CW'(exp_q);
      go_denorm = (raw_w >= exp_w);
      if (!go_denorm)       eff_w = raw_w;
      else if (exp_w == '0) eff_w = '0;
      else                  eff_w = exp_w - CW'(1);
   end

   always_comb begin
      state_d  = state_q;
      mant_d   = mant_q;
      exp_d    = exp_q;
      shamt_d  = shamt_q;
      rem_d    = rem_q;
      zero_d   = zero_q;
      denorm_d = denorm_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               mant_d   = i_mant;
               exp_d    = i_exp;
               shamt_d  = '0;
               rem_d    = '0;
               zero_d   = 1'b0;
               denorm_d = 1'b0;
               state_d  = ST_DETECT;
            end
         end
         ST_DETECT: begin
            if (lop_zero) begin
               mant_d  = '0;
               exp_d   = '0;
               shamt_d = '0;
               rem_d   = '0;
               zero_d  = 1'b1;
               state_d = ST_DONE;
            end else begin
               shamt_d  = SIZE_LOPD'(eff_w);
               rem_d    = SIZE_LOPD'(eff_w);
               exp_d    = go_denorm ? '0 : SIZE_EXP'(exp_w - eff_w);
               denorm_d = go_denorm;
               state_d  = (eff_w == '0) ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
`ifdef LOPD_NORM_FAST_SHIFT_EN
            mant_d  = mant_q << rem_q;
            rem_d   = '0;
            state_d = ST_DONE;
`else
            if (rem_q > SIZE_LOPD'(SHIFT_STEP)) begin
               mant_d = mant_q << SHIFT_STEP;
               rem_d  = rem_q - SIZE_LOPD'(SHIFT_STEP);
            end else begin
               mant_d = mant_q << rem_q;
               rem_d  = '0;
            end
            if (rem_d == '0) state_d = ST_DONE;
`endif
         end
         ST_DONE: begin
            if (i_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         mant_q   <= '0;
         exp_q    <= '0;
         shamt_q  <= '0;
         rem_q    <= '0;
         zero_q   <= 1'b0;
         denorm_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         mant_q   <= mant_d;
         exp_q    <= exp_d;
         shamt_q  <= shamt_d;
         rem_q    <= rem_d;
         zero_q   <= zero_d;
         denorm_q <= denorm_d;
      end
   end

   assign o_ready       = (state_q == ST_IDLE);
   assign o_valid       = (state_q == ST_DONE);
   assign o_mant        = mant_q;
   assign o_exp         = exp_q;
   assign o_shamt       = shamt_q;
   assign o_zero_flag   = zero_q;
   assign o_denorm_flag = denorm_q;

endmodule

// File: tb/tb_lopd_norm_ctrl.sv
// tb_lopd_norm_ctrl: directed and randomized checks of lopd_norm_ctrl
// against a count-leading-zeros reference model. Honors
// LOPD_NORM_FAST_SHIFT_EN for the expected latency.
module tb_lopd_norm_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [23:0] i_mant;
   logic [7:0]  i_exp;
   logic        o_valid;
   logic        i_ready;
   logic [23:0] o_mant;
   logic [7:0]  o_exp;
   logic [4:0]  o_shamt;
   logic        o_zero_flag;
   logic        o_denorm_flag;

   int tests = 0;
   int fails = 0;

   always #5 i_clk = ~i_clk;

   lopd_norm_ctrl dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_mant        (i_mant),
      .i_exp         (i_exp),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_mant        (o_mant),
      .o_exp         (o_exp),
      .o_shamt       (o_shamt),
      .o_zero_flag   (o_zero_flag),
      .o_denorm_flag (o_denorm_flag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Normalization rules: count leading zeros, clamp by exponent, shift.
   task automatic model(input logic [23:0] m, input logic [7:0] e,
                        output logic [23:0] om, output logic [7:0] oe,
                        output logic [4:0] os, output logic oz, output logic od,
                        output int lat);
      int lz;
      int eff;
      logic [23:0] mm;
      mm = m;
      if (mm == 24'd0) begin
         om = 24'd0; oe = 8'd0; os = 5'd0; oz = 1'b1; od = 1'b0; lat = 2;
      end else begin
         lz = 0;
         while (mm[23 - lz] == 1'b0) lz++;
         if (lz < int'(e)) begin
            eff = lz; oe = 8'(int'(e) - lz); od = 1'b0;
         end else begin
            eff = (e == 8'd0) ? 0 : int'(e) - 1; oe = 8'd0; od = 1'b1;
         end
         om = mm << eff;
         os = 5'(eff);
         oz = 1'b0;
`ifdef LOPD_NORM_FAST_SHIFT_EN
         lat = (eff > 0) ? 3 : 2;
`else
         lat = 2 + (eff + 7) / 8;
`endif
      end
   endtask

   task automatic run_op(input logic [23:0] m, input logic [7:0] e, input int hold);
      logic [23:0] em;
      logic [7:0]  ee;
      logic [4:0]  es;
      logic        ez, ed;
      int          lat, cyc;
      model(m, e, em, ee, es, ez, ed, lat);
      @(negedge i_clk);
      chk("ready_idle", 64'(o_ready), 64'd1);
      i_mant = m; i_exp = e; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      cyc = 1;
      while (!o_valid && cyc < 64) begin
         @(posedge i_clk); #1;
         cyc++;
      end
      chk("latency", 64'(cyc), 64'(lat));
      chk("result", {23'd0, o_valid, o_ready, o_mant, o_exp, o_shamt, o_zero_flag, o_denorm_flag},
          {23'd0, 1'b1, 1'b0, em, ee, es, ez, ed});
      // A competing operand offered while DONE must not be taken.
      i_valid = (hold > 0);
      i_mant  = ~m;
      repeat (hold) begin
         @(posedge i_clk); #1;
         chk("hold", {23'd0, o_valid, o_ready, o_mant, o_exp, o_shamt, o_zero_flag, o_denorm_flag},
             {23'd0, 1'b1, 1'b0, em, ee, es, ez, ed});
      end
      @(negedge i_clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk); #1;
      chk("release", {62'd0, o_valid, o_ready}, 64'b01);
      i_ready = 1'b0;
   endtask

   initial begin
      bit seen;
      logic [23:0] rm;
      logic [7:0]  re;
      i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_mant = '0; i_exp = '0;
      #12;
      chk("reset", {23'd0, o_valid, o_ready, o_mant, o_exp, o_shamt, o_zero_flag, o_denorm_flag},
          {23'd0, 1'b0, 1'b1, 24'd0, 8'd0, 5'd0, 1'b0, 1'b0});
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run_op(24'h800000, 8'd100, 0);
      run_op(24'h000001, 8'd100, 0);
      run_op(24'h000010, 8'd5,   0);
      run_op(24'h000000, 8'd50,  0);
      run_op(24'h000001, 8'd100, 4);
      run_op(24'h000003, 8'd0,   1);
      run_op(24'h000100, 8'd16,  0);
      run_op(24'h000100, 8'd15,  2);

      // Reset while SHIFT is in progress discards the operand.
      @(negedge i_clk);
      i_mant = 24'h000001; i_exp = 8'd100; i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      @(posedge i_clk); #1;
      i_rst_n = 1'b0;
      #1;
      chk("mid_reset", {23'd0, o_valid, o_ready, o_mant, o_exp, o_shamt, o_zero_flag, o_denorm_flag},
          {23'd0, 1'b0, 1'b1, 24'd0, 8'd0, 5'd0, 1'b0, 1'b0});
      @(negedge i_clk);
      i_rst_n = 1'b1;
      i_ready = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         @(posedge i_clk); #1;
         if (o_valid) seen = 1'b1;
      end
      chk("no_valid_after_reset", 64'(seen), 64'd0);
      i_ready = 1'b0;

      for (int k = 0; k < 30; k++) begin
         rm = 24'($urandom) >> $urandom_range(0, 24);
         re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
         run_op(rm, re, $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lopd_norm_ctrl.md
LOPD_NORM_CTRL -- requirements
Module: lopd_norm_ctrl

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 24, mantissa width.
REQ-002 SHALL have parameter SIZE_LOPD, default 5, leading-one position width.
REQ-003 SHALL have parameter SIZE_EXP, default 8, biased exponent width.
REQ-004 SHALL have parameter SHIFT_STEP, default 8, maximum left-shift per SHIFT cycle.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_valid, input, 1 bit: input operand valid.
REQ-008 SHALL have port o_ready, output, 1 bit: block can accept an operand.
REQ-009 SHALL have port i_mant, input, SIZE_DATA bits: unnormalized mantissa.
REQ-010 SHALL have port i_exp, input, SIZE_EXP bits: biased exponent.
REQ-011 SHALL have port o_valid, output, 1 bit: result valid.
REQ-012 SHALL have port i_ready, input, 1 bit: downstream accepts result.
REQ-013 SHALL have ports o_mant (SIZE_DATA), o_exp (SIZE_EXP) and o_shamt (SIZE_LOPD), outputs: normalized mantissa, adjusted exponent and applied shift.
REQ-014 SHALL have ports o_zero_flag and o_denorm_flag, outputs, 1 bit each: zero mantissa; result is denormal.

Function
REQ-015 SHALL implement FSM states IDLE, DETECT, SHIFT and DONE.
REQ-016 SHALL drive o_ready = 1 only in IDLE; accept occurs on the edge where i_valid && o_ready, capturing i_mant/i_exp and moving to DETECT.
REQ-017 In DETECT, SHALL compute pos via leading-one detector; raw shamt = SIZE_DATA-1-pos.
REQ-018 Zero mantissa: SHALL set o_zero_flag=1, o_mant=0, o_exp=0, o_shamt=0 and go DETECT->DONE.
REQ-019 If raw shamt < i_exp: eff = raw shamt, o_exp = i_exp - eff, o_denorm_flag=0.
REQ-020 If raw shamt >= i_exp: eff = (i_exp==0) ? 0 : i_exp-1, o_exp = 0, o_denorm_flag=1.
REQ-021 eff==0: DETECT->DONE; else DETECT->SHIFT.
REQ-022 In SHIFT, each cycle SHALL shift left by min(remaining, SHIFT_STEP) and decrement remaining; remaining==0 after the update -> DONE.
REQ-023 o_valid SHALL be 1 only in DONE; results held stable while o_valid && !i_ready.
REQ-024 DONE->IDLE on o_valid && i_ready; no same-cycle accept (o_ready rises the following cycle).
REQ-025 Latency, accept edge to first o_valid cycle: 2 + ceil(eff/SHIFT_STEP) cycles.
REQ-026 All arithmetic unsigned; o_exp never wraps below 0.

Reset
REQ-027 i_rst_n low SHALL immediately force IDLE, o_valid=0, o_ready=1 (after release: 1), and o_mant, o_exp, o_shamt, o_zero_flag, o_denorm_flag to 0.
REQ-028 Reset mid-operation SHALL discard the in-flight operand; no o_valid pulse follows.

Configuration
REQ-029 Macro LOPD_NORM_FAST_SHIFT_EN defined: SHIFT SHALL last exactly one cycle applying full eff; latency 3 when eff>0, else 2.
REQ-030 Macro undefined: iterative SHIFT_STEP behaviour of REQ-022 applies.

Structure
REQ-031 Shared package lopd_norm_pkg SHALL hold the FSM state enum typedef and default width constants.
REQ-032 Leading-one detection SHALL be a combinational sub-module lopd_core (i_data -> o_one_position, o_zero_flag) instantiated once.

Verification
REQ-033 Reset: i_rst_n=0 -> o_valid=0, o_ready=1, all data outputs 0.
REQ-034 i_mant=24'h800000, i_exp=8'd100 -> o_mant=24'h800000, o_exp=100, o_shamt=0, o_valid 2 cycles after accept.
REQ-035 i_mant=24'h000001, i_exp=8'd100 -> o_mant=24'h800000, o_exp=77, o_shamt=23; o_valid after 5 cycles (3 with LOPD_NORM_FAST_SHIFT_EN).
REQ-036 i_mant=24'h000010, i_exp=8'd5 -> o_shamt=4, o_exp=0, o_mant=24'h000100, o_denorm_flag=1.
REQ-037 i_mant=0, i_exp=8'd50 -> o_zero_flag=1, o_exp=0, o_mant=0; o_valid 2 cycles after accept.
REQ-038 i_ready held 0 for 4 cycles in DONE -> outputs stable, o_ready=0; reset asserted in SHIFT -> IDLE, no o_valid.
